// File: rtl/edsac_word_deserializer.sv
// EDSAC serial word recovery: counts synchronised pulse edges per digit slot,
// decides each digit and assembles MSB-first 35-bit words framed by a spacing slot.
module edsac_word_deserializer #(
   parameter int BIT_CYCLES = 200,
   parameter int NUM_WIDTH  = 35,
   parameter int MIN_EDGES  = 4
) (
   input  logic                 clk_in,
   input  logic                 rst,
   input  logic                 in_sig,
   input  logic                 align,
   output logic                 bit_out,
   output logic                 bit_valid,
   output logic [NUM_WIDTH-1:0] word_out,
   output logic                 word_valid,
   output logic                 spacing_err
);

   localparam int SLOT_W  = $clog2(BIT_CYCLES);
   localparam int DIGIT_W = $clog2(NUM_WIDTH + 1);

   // Edge counter never wraps so long bursts still read as a one.
   function automatic logic [3:0] sat_inc(input logic [3:0] cnt, input logic inc);
      if (inc && cnt != 4'hF)
         return cnt + 4'd1;
      return cnt;
   endfunction

   function automatic logic decide(input logic [3:0] cnt);
      return cnt >= 4'(MIN_EDGES);
   endfunction

   logic                 in_sync_p0;
   logic                 in_sync_p1;
   logic                 in_prev_p2;
   logic                 edge_p2;
   logic [SLOT_W-1:0]    slot_cnt;
   logic [DIGIT_W-1:0]   digit;
   logic [3:0]           edge_cnt;
   logic [3:0]           edge_cnt_nxt;
   logic [NUM_WIDTH-1:0] shreg;
   logic                 slot_end;
   logic                 bit_dec;

   // Stage p0/p1: synchroniser; p2: previous-value register for rising-edge detect
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         in_sync_p0 <= 1'b0;
         in_sync_p1 <= 1'b0;
         in_prev_p2 <= 1'b0;
      end else begin
         in_sync_p0 <= in_sig;
         in_sync_p1 <= in_sync_p0;
         in_prev_p2 <= in_sync_p1;
      end
   end

   assign edge_p2      = in_sync_p1 & ~in_prev_p2;
   assign edge_cnt_nxt = sat_inc(edge_cnt, edge_p2);
   assign slot_end     = (slot_cnt == SLOT_W'(BIT_CYCLES - 1));
   assign bit_dec      = decide(edge_cnt_nxt);

   // Slot / frame stage: the edge on the slot-end cycle still counts toward the decision
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         slot_cnt    <= '0;
         digit       <= '0;
         edge_cnt    <= '0;
         shreg       <= '0;
         bit_out     <= 1'b0;
         bit_valid   <= 1'b0;
         word_out    <= '0;
         word_valid  <= 1'b0;
         spacing_err <= 1'b0;
      end else begin
         bit_valid  <= 1'b0;
         word_valid <= 1'b0;
         if (align) begin
            slot_cnt    <= '0;
            digit       <= '0;
            edge_cnt    <= '0;
            shreg       <= '0;
            spacing_err <= 1'b0;
         end else if (slot_end) begin
            slot_cnt <= '0;
            edge_cnt <= '0;
            if (digit < DIGIT_W'(NUM_WIDTH)) begin
               shreg     <= {shreg[NUM_WIDTH-2:0], bit_dec};
               bit_out   <= bit_dec;
               bit_valid <= 1'b1;
               digit     <= digit + DIGIT_W'(1);
            end else begin
               word_out    <= shreg;
               word_valid  <= 1'b1;
               spacing_err <= spacing_err | bit_dec;
               digit       <= '0;
            end
         end else begin
            slot_cnt <= slot_cnt + SLOT_W'(1);
            edge_cnt <= edge_cnt_nxt;
         end
      end
   end

endmodule

// File: tb/tb_edsac_word_deserializer.sv
// Directed bench for edsac_word_deserializer: drives pulse bursts per slot and
// checks every digit strobe, word strobe timing and the spacing error flag.
`timescale 1ns/1ps
module tb_edsac_word_deserializer;

   localparam int BIT = 200;
   localparam int NW  = 35;
   localparam int FRAME = 36 * BIT;

   logic          clk_in;
   logic          rst;
   logic          in_sig;
   logic          align;
   logic          bit_out;
   logic          bit_valid;
   logic [NW-1:0] word_out;
   logic          word_valid;
   logic          spacing_err;

   int checks = 0;
   int errors = 0;

   edsac_word_deserializer #(.BIT_CYCLES(BIT), .NUM_WIDTH(NW), .MIN_EDGES(4)) dut (
      .clk_in(clk_in),
      .rst(rst),
      .in_sig(in_sig),
      .align(align),
      .bit_out(bit_out),
      .bit_valid(bit_valid),
      .word_out(word_out),
      .word_valid(word_valid),
      .spacing_err(spacing_err)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   // 74 ns period pulses, 37 ns high
   task automatic pulses(input int n);
      for (int i = 0; i < n; i++) begin
         in_sig = 1'b1;
         #37;
         in_sig = 1'b0;
         #37;
      end
   endtask

   // Called 1 ns after the edge that leaves slot_cnt = 0, digit = 0 current.
   task automatic run_frame(input logic [NW-1:0] w, input int p1, input int p0, input int psp,
                            input logic [NW-1:0] prev_word, input logic serr_before,
                            input logic serr_after, input string name);
      fork
         begin
            for (int s = 0; s < 36; s++) begin
               int n;
               if (s == 35) n = psp;
               else if (w[NW-1-s]) n = p1;
               else n = p0;
               fork
                  pulses(n);
                  repeat (BIT) @(posedge clk_in);
               join
               #1;
            end
         end
         begin
            for (int e = 1; e <= FRAME; e++) begin
               @(posedge clk_in);
               #1;
               if (e % BIT == 0 && e < FRAME) begin
                  int d;
                  d = e / BIT - 1;
                  checks++;
                  if (bit_valid !== 1'b1 || bit_out !== w[NW-1-d]) begin
                     errors++;
                     $display("FAIL %s digit%0d: bit_valid=%b bit_out=%b required 1 %b",
                              name, d, bit_valid, bit_out, w[NW-1-d]);
                  end
               end else if (bit_valid !== 1'b0) begin
                  checks++;
                  errors++;
                  $display("FAIL %s stray bit_valid at cycle %0d: got %b required 0", name, e, bit_valid);
               end
               if (e == FRAME - 1) begin
                  checks++;
                  if (word_out !== prev_word || spacing_err !== serr_before) begin
                     errors++;
                     $display("FAIL %s pre-strobe: word_out=%h spacing_err=%b required %h %b",
                              name, word_out, spacing_err, prev_word, serr_before);
                  end
               end
               if (e == FRAME) begin
                  checks++;
                  if (word_valid !== 1'b1 || word_out !== w) begin
                     errors++;
                     $display("FAIL %s word: word_valid=%b word_out=%h required 1 %h",
                              name, word_valid, word_out, w);
                  end
                  checks++;
                  if (spacing_err !== serr_after) begin
                     errors++;
                     $display("FAIL %s spacing_err: got %b required %b", name, spacing_err, serr_after);
                  end
               end else if (word_valid !== 1'b0) begin
                  checks++;
                  errors++;
                  $display("FAIL %s stray word_valid at cycle %0d: got %b required 0", name, e, word_valid);
               end
            end
         end
      join
   endtask

   task automatic test_reset();
      rst    = 1'b1;
      in_sig = 1'b0;
      align  = 1'b0;
      repeat (3) @(posedge clk_in);
      #1;
      checks++;
      if ({bit_out, bit_valid, word_valid, spacing_err} !== 4'b0000 || word_out !== '0) begin
         errors++;
         $display("FAIL reset outputs: bit_out=%b bit_valid=%b word_valid=%b spacing_err=%b word_out=%h required all 0",
                  bit_out, bit_valid, word_valid, spacing_err, word_out);
      end
      rst = 1'b0;
   endtask

   task automatic test_all_ones();
      run_frame(35'h7FFFFFFFF, 12, 0, 0, 35'h0, 1'b0, 1'b0, "all_ones");
   endtask

   task automatic test_back_to_back();
      run_frame(35'h2AAAAAAAA, 12, 0, 0, 35'h7FFFFFFFF, 1'b0, 1'b0, "b2b_a");
      run_frame(35'h555555555, 12, 0, 0, 35'h2AAAAAAAA, 1'b0, 1'b0, "b2b_5");
   endtask

   task automatic test_threshold();
      run_frame(35'h2AAAAAAAA, 4, 3, 0, 35'h555555555, 1'b0, 1'b0, "threshold");
   endtask

   task automatic test_saturation();
      run_frame(35'h3C3C3C3C3, 17, 0, 0, 35'h2AAAAAAAA, 1'b0, 1'b0, "saturate");
   endtask

   task automatic test_spacing();
      run_frame(35'h123456789, 12, 0, 6, 35'h3C3C3C3C3, 1'b0, 1'b1, "spacing_burst");
      run_frame(35'h0F0F0F0F0, 12, 0, 0, 35'h123456789, 1'b1, 1'b1, "spacing_sticky");
   endtask

   task automatic test_align();
      int strobes;
      strobes = 0;
      repeat (17 * BIT + 57) begin
         @(posedge clk_in);
         #1;
         if (word_valid === 1'b1) strobes++;
      end
      checks++;
      if (strobes != 0) begin
         errors++;
         $display("FAIL align partial word_valid count: got %0d required 0", strobes);
      end
      align = 1'b1;
      @(posedge clk_in);
      #1;
      align = 1'b0;
      checks++;
      if (word_valid !== 1'b0 || bit_valid !== 1'b0 || spacing_err !== 1'b0 || word_out !== 35'h0F0F0F0F0) begin
         errors++;
         $display("FAIL align cycle: word_valid=%b bit_valid=%b spacing_err=%b word_out=%h required 0 0 0 0f0f0f0f0",
                  word_valid, bit_valid, spacing_err, word_out);
      end
      run_frame(35'h6DB6DB6DB, 12, 0, 0, 35'h0F0F0F0F0, 1'b0, 1'b0, "after_align");
   endtask

   task automatic test_reset_mid();
      fork
         pulses(10);
      join_none
      #300;
      rst = 1'b1;
      #1;
      checks++;
      if ({bit_out, bit_valid, word_valid, spacing_err} !== 4'b0000 || word_out !== '0) begin
         errors++;
         $display("FAIL mid reset outputs: bit_out=%b bit_valid=%b word_valid=%b spacing_err=%b word_out=%h required all 0",
                  bit_out, bit_valid, word_valid, spacing_err, word_out);
      end
      #800;
      in_sig = 1'b0;
      @(posedge clk_in);
      #1;
      rst = 1'b0;
      run_frame(35'h0, 12, 0, 0, 35'h0, 1'b0, 1'b0, "after_reset");
   endtask

   initial begin
      test_reset();
      test_all_ones();
      test_back_to_back();
      test_threshold();
      test_saturation();
      test_spacing();
      test_align();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/edsac_word_deserializer.md
# edsac_word_deserializer

Recovers EDSAC serial words from the pulse-train output of the delay line. Each digit slot carries either a 13.5 MHz burst (1) or silence (0). The block counts synchronised rising edges per slot, decides each digit, and shifts the digits MSB-first into a 35-bit word. It presents that word on a one-cycle strobe at the end of each 36-slot frame (35 digits plus 1 spacing slot). It sits directly downstream of `delay_line_wrapper.out_sig` and feeds the store/arithmetic logic.

## Interface
- `BIT_CYCLES`, 200: clock cycles per digit slot (2.0 µs at 100 MHz).
- `NUM_WIDTH`, 35: data digits per word, excluding the spacing slot.
- `MIN_EDGES`, 4: minimum rising edges in one slot for the digit to count as 1.
- `clk_in`, input, 1: system clock, 100 MHz.
- `rst`, input, 1: asynchronous, active-high reset.
- `in_sig`, input, 1: asynchronous pulse train from the delay line.
- `align`, input, 1: synchronous frame restart from the timing generator; sampled on `clk_in`.
- `bit_out`, output, 1: decided value of the slot that just ended.
- `bit_valid`, output, 1: one-cycle strobe qualifying `bit_out`.
- `word_out`, output, `NUM_WIDTH`: last complete word. Digit 0 is the first-received digit and lands at the MSB.
- `word_valid`, output, 1: one-cycle strobe qualifying `word_out`.
- `spacing_err`, output, 1: sticky flag, set when the spacing slot holds a burst; cleared by `rst` or `align`.

## Operation
- Input path: `in_sig` passes through a 2-flop synchroniser and then an edge register. `edge` = synced & ~previous.
- `slot_cnt` counts 0..`BIT_CYCLES`-1 and wraps. `digit` counts 0..`NUM_WIDTH` and wraps. `edge_cnt` is 4 bits and saturates at 15.
- Every `edge` cycle increments `edge_cnt`, including an edge on the cycle where `slot_cnt` = `BIT_CYCLES`-1.
- Slot end is the cycle where `slot_cnt` = `BIT_CYCLES`-1. On that cycle:
  - decided bit = (next `edge_cnt` ≥ `MIN_EDGES`);
  - `edge_cnt` is cleared for the next slot.
- Data slot end (`digit` < `NUM_WIDTH`):
  - `shreg` <= {`shreg`[`NUM_WIDTH`-2:0], bit};
  - `bit_out` <= bit, `bit_valid` <= 1;
  - `digit` increments.
- Spacing slot end (`digit` = `NUM_WIDTH`):
  - `word_out` <= `shreg`, `word_valid` <= 1;
  - `spacing_err` <= `spacing_err` | bit;
  - `bit_out`/`bit_valid` are not pulsed;
  - `digit` <= 0.
- `align` high forces the following, and overrides slot-end processing on the same cycle:
  - `slot_cnt`, `digit`, `edge_cnt`, `shreg` <= 0;
  - `spacing_err` <= 0;
  - no strobe on that cycle.
- A partial word interrupted by `align` is discarded. `word_out` keeps its previous value.
- State machine: none beyond the two counters. The frame position is fully defined by (`digit`, `slot_cnt`).

## Timing
- Reset values: all outputs 0, all counters 0, `shreg` 0, synchroniser flops 0.
- Reset mid-word: the partial word is lost. After `rst` falls, the frame restarts at digit 0, slot cycle 0.
- Free-running: the first slot begins on the first `clk_in` edge after `rst` deasserts, or on the cycle after `align`.
- Edge-detect latency: 3 cycles from a `in_sig` rise to `edge_cnt` increment. Upstream must place bursts so that they end ≥ 4 cycles before slot end.
- `bit_valid` and `word_valid` assert on the cycle after slot end and last exactly 1 cycle.
- Word period: 36 × `BIT_CYCLES` = 7200 cycles. The first `word_valid` after align/reset comes 7201 cycles later.
- `word_out` is stable from the `word_valid` cycle until the next `word_valid`.
- Edge counting never wraps (saturates at 15), so bursts longer than 15 pulses still decode as 1.

## Test plan
- All-ones word: 36 slots, each digit slot carrying 12 pulses at 74 ns period, spacing slot silent -> `word_out` = 35'h7FFFFFFFF, `word_valid` at cycle 7201, `spacing_err` = 0.
- Pattern 35'h2AAAAAAAA, then 35'h555555555, back-to-back -> two `word_valid` strobes 7200 cycles apart with matching values. Bench also checks every `bit_valid`/`bit_out`.
- Threshold: digit slots carrying 3 pulses decode as 0, slots carrying 4 pulses decode as 1. Alternating 3/4 pulses per digit -> `word_out` = 35'h2AAAAAAAA.
- Burst placed in the spacing slot -> `spacing_err` rises the cycle after slot 35 ends, stays set across later clean words, clears on `align`.
- `align` pulsed at digit 17 -> no `word_valid` for the partial word. Next `word_valid` comes 7201 cycles after `align`. `word_out` holds the old value until then.
- `rst` asserted mid-slot with edges arriving -> all outputs 0 immediately. After release, an all-zeros frame yields `word_out` = 0 at cycle 7201.
